// File: rtl/cnn_conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution with two line buffers and a 3-stage MAC pipeline.
// Optional feature macro: CNN_RELU_EN selects ReLU/unsigned saturation instead of signed saturation.
module cnn_conv3x3_stream #(
  parameter int IMAGE_WIDTH  = 16,
  parameter int IMAGE_HEIGHT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SHIFT        = 0
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStart,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iValid,
  input  logic                  iWeightWe,
  input  logic [3:0]            iWeightAddr,
  input  logic [7:0]            iWeightData,
  output logic [DATA_WIDTH-1:0] oResult,
  output logic                  oValid,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam int COL_W  = (IMAGE_WIDTH  > 2) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int ROW_W  = (IMAGE_HEIGHT > 2) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int PROD_W = DATA_WIDTH + 9;
  localparam int ACC_W  = DATA_WIDTH + 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_nx_s;
  logic [1:0]                drain_cnt_r;
  logic [COL_W-1:0]          col_r;
  logic [ROW_W-1:0]          row_r;
  logic                      accept_s;
  logic                      adv_s;
  logic                      last_pix_s;
  logic                      win_ok_s;

  logic signed [7:0]         w_r [9];
  logic [DATA_WIDTH-1:0]     lb1_r [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0]     lb2_r [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0]     win_r [9];
  logic [DATA_WIDTH-1:0]     win_nx_s [9];
  logic [DATA_WIDTH-1:0]     new_col_s [3];

  logic signed [PROD_W-1:0]  prod_s [9];
  logic signed [PROD_W-1:0]  prod_r [9];
  logic                      v1_r;
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [ACC_W-1:0]   sum_r;
  logic                      v2_r;
  logic signed [ACC_W-1:0]   shifted_s;

  logic [DATA_WIDTH-1:0]     result_r;
  logic                      valid_r;
  logic                      busy_r;
  logic                      done_r;

  // Zero-extended pixel times signed weight.
  function automatic logic signed [PROD_W-1:0] mul_px(
    input logic [DATA_WIDTH-1:0] px,
    input logic signed [7:0]     w
  );
    logic signed [DATA_WIDTH:0] pe;
    pe = {1'b0, px};
    return pe * w;
  endfunction

  // Clamp the shifted accumulator into the output range.
  function automatic logic [DATA_WIDTH-1:0] sat_res(input logic signed [ACC_W-1:0] v);
`ifdef CNN_RELU_EN
    if (v[ACC_W-1]) begin
      return {DATA_WIDTH{1'b0}};
    end else if (|v[ACC_W-2:DATA_WIDTH]) begin
      return {DATA_WIDTH{1'b1}};
    end else begin
      return v[DATA_WIDTH-1:0];
    end
`else
    if (v[ACC_W-1] && !(&v[ACC_W-2:DATA_WIDTH-1])) begin
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else if (!v[ACC_W-1] && (|v[ACC_W-2:DATA_WIDTH-1])) begin
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      return v[DATA_WIDTH-1:0];
    end
`endif
  endfunction

  assign accept_s   = (state_r == ST_RUN) && iValid;
  assign adv_s      = accept_s || (state_r == ST_DRAIN);
  assign last_pix_s = (col_r == COL_W'(IMAGE_WIDTH - 1)) && (row_r == ROW_W'(IMAGE_HEIGHT - 1));
  assign win_ok_s   = (col_r >= COL_W'(2)) && (row_r >= ROW_W'(2));

  // State register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (iStart) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && last_pix_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == 2'd2) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Drain cycle counter.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      drain_cnt_r <= 2'd0;
    end else if (state_r == ST_DRAIN) begin
      drain_cnt_r <= drain_cnt_r + 2'd1;
    end else begin
      drain_cnt_r <= 2'd0;
    end
  end

  // Raster position of the next accepted pixel.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if ((state_r == ST_IDLE) && iStart) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (accept_s) begin
      if (col_r == COL_W'(IMAGE_WIDTH - 1)) begin
        col_r <= {COL_W{1'b0}};
        row_r <= row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Weight file; writes land only while idle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < 9; i++) begin
        w_r[i] <= (i == 4) ? 8'sd1 : 8'sd0;
      end
    end else if ((state_r == ST_IDLE) && iWeightWe) begin
      for (int i = 0; i < 9; i++) begin
        if (iWeightAddr == 4'(i)) begin
          w_r[i] <= iWeightData;
        end
      end
    end
  end

  // Line buffers: lb1 tail is the pixel one row up, lb2 tail two rows up.
  always_ff @(posedge iClk) begin
    if (accept_s) begin
      lb1_r[0] <= iData;
      lb2_r[0] <= lb1_r[IMAGE_WIDTH-1];
      for (int i = 1; i < IMAGE_WIDTH; i++) begin
        lb1_r[i] <= lb1_r[i-1];
        lb2_r[i] <= lb2_r[i-1];
      end
    end
  end

  // Window after shifting in the column for the incoming pixel.
  always_comb begin
    new_col_s[0] = lb2_r[IMAGE_WIDTH-1];
    new_col_s[1] = lb1_r[IMAGE_WIDTH-1];
    new_col_s[2] = iData;
    for (int r = 0; r < 3; r++) begin
      win_nx_s[r*3+0] = win_r[r*3+1];
      win_nx_s[r*3+1] = win_r[r*3+2];
      win_nx_s[r*3+2] = new_col_s[r];
    end
  end

  // Window register, one column per accepted pixel.
  always_ff @(posedge iClk) begin
    if (accept_s) begin
      for (int i = 0; i < 9; i++) begin
        win_r[i] <= win_nx_s[i];
      end
    end
  end

  // Nine products from the post-shift window.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod_s[i] = mul_px(win_nx_s[i], w_r[i]);
    end
  end

  // Stage 1: multiply.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      v1_r <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        prod_r[i] <= {PROD_W{1'b0}};
      end
    end else if (adv_s) begin
      v1_r <= accept_s && win_ok_s;
      for (int i = 0; i < 9; i++) begin
        prod_r[i] <= prod_s[i];
      end
    end
  end

  // Full-width adder tree.
  always_comb begin
    sum_s = {ACC_W{1'b0}};
    for (int i = 0; i < 9; i++) begin
      sum_s = sum_s + ACC_W'(prod_r[i]);
    end
  end

  // Stage 2: accumulate.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sum_r <= {ACC_W{1'b0}};
      v2_r  <= 1'b0;
    end else if (adv_s) begin
      sum_r <= sum_s;
      v2_r  <= v1_r;
    end
  end

  assign shifted_s = sum_r >>> SHIFT;

  // Stage 3: shift/saturate; oValid is a single pulse per advancing cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      result_r <= {DATA_WIDTH{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      valid_r <= adv_s && v2_r;
      if (adv_s && v2_r) begin
        result_r <= sat_res(shifted_s);
      end
    end
  end

  // Frame status outputs; done lines up with the last result.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      done_r <= (state_r == ST_DRAIN) && (drain_cnt_r == 2'd1);
    end
  end

  assign oResult = result_r;
  assign oValid  = valid_r;
  assign oBusy   = busy_r;
  assign oDone   = done_r;

endmodule

// File: tb/tb_cnn_conv3x3_stream.sv
// Directed bench for cnn_conv3x3_stream: table of frames plus reset/stall sequences.
// Two instances share the stimulus: SHIFT=0 and SHIFT=2.
module tb_cnn_conv3x3_stream;

  logic       clk = 1'b0;
  logic       rst, start, vld, wwe;
  logic [7:0] data, wdata;
  logic [3:0] waddr;
  logic [7:0] res0, res2;
  logic       ov0, ov2, busy0, busy2, done0, done2;

  cnn_conv3x3_stream #(.IMAGE_WIDTH(16), .IMAGE_HEIGHT(16), .DATA_WIDTH(8), .SHIFT(0)) dut0 (
    .iClk(clk), .iRst(rst), .iStart(start), .iData(data), .iValid(vld),
    .iWeightWe(wwe), .iWeightAddr(waddr), .iWeightData(wdata),
    .oResult(res0), .oValid(ov0), .oBusy(busy0), .oDone(done0)
  );

  cnn_conv3x3_stream #(.IMAGE_WIDTH(16), .IMAGE_HEIGHT(16), .DATA_WIDTH(8), .SHIFT(2)) dut2 (
    .iClk(clk), .iRst(rst), .iStart(start), .iData(data), .iValid(vld),
    .iWeightWe(wwe), .iWeightAddr(waddr), .iWeightData(wdata),
    .oResult(res2), .oValid(ov2), .oBusy(busy2), .oDone(done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectation set up by the main sequence (0 ignore, 1 identity ramp, 2 constant).
  int exp_kind = 0;
  int exp0 = 0;
  int exp2 = 0;
  int res_base = 0;

  // Observations collected by the monitor.
  int res_cnt = 0, bad_cnt = 0, done_cnt = 0, done_vld_cnt = 0;
  int first_valid_cyc = 0, done_cyc = 0, busy_fall_cyc = 0;
  int bad_k = 0, bad_got0 = 0, bad_got2 = 0, bad_want0 = 0, bad_want2 = 0;
  logic prev_busy = 1'b0;
  int mk, mpix, me0, me2;

  int checks = 0;
  int errors = 0;

  function automatic int sat_id(input int p);
`ifdef CNN_RELU_EN
    return p;
`else
    return (p > 127) ? 127 : p;
`endif
  endfunction

  always @(negedge clk) begin
    if (ov0 || ov2) begin
      mk = res_cnt - res_base;
      if (mk == 0) first_valid_cyc = cyc;
      if (exp_kind == 1) begin
        mpix = 16 * (mk / 14 + 1) + (mk % 14 + 1);
        me0  = sat_id(mpix);
        me2  = mpix >> 2;
      end else begin
        me0 = exp0;
        me2 = exp2;
      end
      if (exp_kind != 0 && (!ov0 || !ov2 || int'(res0) != me0 || int'(res2) != me2)) begin
        if (bad_cnt == 0) begin
          bad_k = mk; bad_got0 = int'(res0); bad_got2 = int'(res2);
          bad_want0 = me0; bad_want2 = me2;
        end
        bad_cnt++;
      end
      res_cnt++;
    end
    if (done0) begin
      done_cnt++;
      done_cyc = cyc;
      if (ov0) done_vld_cnt++;
    end
    if (prev_busy && !busy0) busy_fall_cyc = cyc;
    prev_busy = busy0;
  end

  typedef struct {
    int wmode;   // 0 none, 1 all ones, 2 centre -1, 3 identity with w4 written alongside iStart
    int ramp;
    int pix;
    int e0;
    int e2;
    int gaps;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic write_w(input int a, input int d);
    wwe = 1'b1; waddr = 4'(a); wdata = 8'(d);
    tick();
    wwe = 1'b0;
  endtask

  task automatic load_weights(input int mode);
    for (int i = 0; i < 9; i++) begin
      case (mode)
        1: write_w(i, 1);
        2: write_w(i, (i == 4) ? 8'hFF : 0);
        3: if (i != 4) write_w(i, 0);
        default: ;
      endcase
    end
    if (mode != 0) write_w(9, 8'h55);
  endtask

  task automatic run_frame(input int vi);
    int res_b, done_b, bad_b, dv_b, p22, gn, idx;
    load_weights(tbl[vi].wmode);
    exp_kind = tbl[vi].ramp ? 1 : 2;
    exp0 = tbl[vi].e0;
    exp2 = tbl[vi].e2;
    res_base = res_cnt;
    res_b = res_cnt; done_b = done_cnt; bad_b = bad_cnt; dv_b = done_vld_cnt;
    p22 = 0; idx = 0;
    chk($sformatf("v%0d busy before start", vi), int'(busy0), 0);
    start = 1'b1;
    if (tbl[vi].wmode == 3) begin
      wwe = 1'b1; waddr = 4'd4; wdata = 8'd1;
    end
    tick();
    start = 1'b0; wwe = 1'b0;
    chk($sformatf("v%0d busy after start", vi), int'(busy0), 1);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        if (tbl[vi].gaps != 0) begin
          gn = $urandom_range(1, 3);
          for (int g = 0; g < gn; g++) begin
            vld = 1'b0;
            data = 8'($urandom);
            if (g == 0 && (idx % 37) == 5) begin
              start = 1'b1; wwe = 1'b1; waddr = 4'd4; wdata = 8'd3;
            end
            tick();
            start = 1'b0; wwe = 1'b0;
          end
        end
        vld = 1'b1;
        data = tbl[vi].ramp ? 8'(16 * r + c) : 8'(tbl[vi].pix);
        if (r == 2 && c == 2) p22 = cyc;
        tick();
        idx++;
      end
    end
    vld = 1'b0;
    for (int t = 0; t < 40 && done_cnt == done_b; t++) tick();
    for (int t = 0; t < 5; t++) tick();
    if (bad_cnt != bad_b)
      $display("v%0d first bad result k=%0d got %0d/%0d want %0d/%0d",
               vi, bad_k, bad_got0, bad_got2, bad_want0, bad_want2);
    chk($sformatf("v%0d result count", vi), res_cnt - res_b, 196);
    chk($sformatf("v%0d wrong results", vi), bad_cnt - bad_b, 0);
    chk($sformatf("v%0d done pulses", vi), done_cnt - done_b, 1);
    chk($sformatf("v%0d done with last valid", vi), done_vld_cnt - dv_b, 1);
    chk($sformatf("v%0d busy falls after done", vi), busy_fall_cyc, done_cyc + 1);
    chk($sformatf("v%0d busy idle", vi), int'(busy0), 0);
    if (tbl[vi].gaps == 0)
      chk($sformatf("v%0d first valid latency", vi), first_valid_cyc - p22, 3);
  endtask

  initial begin
    // Raster ramp under identity from reset weights (first 0x11, last 0xEE before saturation).
    tbl[0] = '{wmode: 0, ramp: 1, pix: 0, e0: 0, e2: 0, gaps: 0};
    // Box filter of 10: 90, SHIFT 2 gives 22.
    tbl[1] = '{wmode: 1, ramp: 0, pix: 10, e0: 90, e2: 22, gaps: 0};
`ifdef CNN_RELU_EN
    // Box filter of 255: sum 2295, >>2 = 573, both clamp to 255.
    tbl[2] = '{wmode: 1, ramp: 0, pix: 255, e0: 255, e2: 255, gaps: 0};
    // Centre -1 on 5: -5 and -2 both clamp to 0.
    tbl[3] = '{wmode: 2, ramp: 0, pix: 5, e0: 0, e2: 0, gaps: 0};
`else
    tbl[2] = '{wmode: 1, ramp: 0, pix: 255, e0: 127, e2: 127, gaps: 0};
    // -5 = 0xFB, -5 >>> 2 = -2 = 0xFE.
    tbl[3] = '{wmode: 2, ramp: 0, pix: 5, e0: 251, e2: 254, gaps: 0};
`endif
    // Ramp with stalls; identity restored with w4 written in the iStart cycle.
    tbl[4] = '{wmode: 3, ramp: 1, pix: 0, e0: 0, e2: 0, gaps: 1};
    // Ramp after mid-frame reset, relying on reset weights.
    tbl[5] = '{wmode: 0, ramp: 1, pix: 0, e0: 0, e2: 0, gaps: 0};

    rst = 1'b1; start = 1'b0; vld = 1'b0; wwe = 1'b0;
    data = 8'd0; waddr = 4'd0; wdata = 8'd0;
    tick(); tick();
    chk("reset oValid", int'(ov0), 0);
    chk("reset oResult", int'(res0), 0);
    chk("reset oBusy", int'(busy0), 0);
    chk("reset oDone", int'(done0), 0);
    chk("reset oValid shift2", int'(ov2), 0);
    rst = 1'b0;
    tick();

    // iValid while idle must not move the raster counters.
    for (int i = 0; i < 5; i++) begin
      vld = 1'b1; data = 8'($urandom);
      tick();
    end
    vld = 1'b0;
    tick();
    chk("idle iValid busy", int'(busy0), 0);

    for (int v = 0; v < 5; v++) run_frame(v);

    // Abort a frame with all-ones weights after 100 pixels.
    load_weights(1);
    exp_kind = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      vld = 1'b1; data = 8'(i);
      tick();
    end
    rst = 1'b1;
    vld = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid-reset oValid %0d", i), int'(ov0), 0);
      chk($sformatf("mid-reset oResult %0d", i), int'(res0), 0);
      chk($sformatf("mid-reset oBusy %0d", i), int'(busy0), 0);
      chk($sformatf("mid-reset oDone %0d", i), int'(done0), 0);
    end
    tick();
    rst = 1'b0;
    tick();
    run_frame(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_conv3x3_stream.md
# cnn_conv3x3_stream

Parametrised streaming 3×3 convolution engine, the next generation of the CNN core datapath. It accepts a raster-scan pixel stream of a configurable IMAGE_WIDTH × IMAGE_HEIGHT frame, buffers two lines internally, and emits one "valid" (unpadded) convolution result per complete 3×3 window. Results are right-shifted and saturated. It sits between the tile loader and the pooling/output stage, and is framed by the same iStart/iValid protocol used across the CNN pipeline.

## Interface
- IMAGE_WIDTH, 16, pixels per line, ≥3.
- IMAGE_HEIGHT, 16, lines per frame, ≥3.
- DATA_WIDTH, 8, pixel width in bits (unsigned), 4–16.
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation, 0–15.
- iClk  in  1  clock; all logic is rising-edge.
- iRst  in  1  reset, synchronous, active-high.
- iStart  in  1  one-cycle pulse that arms a new frame; honoured only in IDLE.
- iData  in  DATA_WIDTH  pixel, unsigned.
- iValid  in  1  iData is valid this cycle; honoured only in RUN.
- iWeightWe  in  1  weight write strobe; honoured only in IDLE.
- iWeightAddr  in  4  weight index 0–8, row-major (0 = top-left, 4 = centre); 9–15 ignored.
- iWeightData  in  8  signed weight.
- oResult  out  DATA_WIDTH  saturated result.
- oValid  out  1  oResult is valid.
- oBusy  out  1  high in RUN and DRAIN.
- oDone  out  1  one-cycle pulse when the last result of a frame has been emitted.

## Operation
- States: IDLE → RUN on iStart. RUN → DRAIN on the accepted pixel IMAGE_WIDTH·IMAGE_HEIGHT. DRAIN → IDLE after 3 cycles, with oDone asserted in the final DRAIN cycle. The oDone cycle coincides with the oValid of the last result.
- Reset: state = IDLE; col/row counters = 0; pipeline valids = 0; oResult = 0, oValid = 0, oBusy = 0, oDone = 0. Weights reset to identity: w[4] = 1, all others 0. Line-buffer contents are don't-care.
- Counters:
  - col counts 0…IMAGE_WIDTH−1 and advances only on accepted pixels.
  - row increments when col wraps.
  - Both clear on entering RUN.
- Line buffers: two IMAGE_WIDTH-deep DATA_WIDTH shift/RAM lines hold rows r−1 and r−2. The 3×3 window register shifts one column per accepted pixel.
- Window valid when row ≥ 2 and col ≥ 2. This gives (IMAGE_WIDTH−2)·(IMAGE_HEIGHT−2) results per frame, in raster order. No padding; there is no wrap across line ends.
- Arithmetic:
  - Each product is the zero-extended pixel × the signed weight.
  - The sum of nine products is kept at full width, DATA_WIDTH+13 bits signed.
  - The sum is arithmetic-shifted right by SHIFT, then saturated (see Configuration).
- iValid gaps (stalls) are allowed anywhere. The pipeline advances only on accepted pixels, except DRAIN, which free-runs.
- iStart during RUN/DRAIN: ignored. iValid in IDLE: ignored, and no state changes. Weight writes outside IDLE: ignored.
- Simultaneous iStart and iWeightWe in IDLE: the write takes effect and is used by the frame being started.
- iRst mid-frame: immediate return to IDLE with all outputs 0. Weights return to identity.

## Timing
- Pipeline is 3 stages: multiply, adder tree, shift/saturate register.
- oValid rises 3 cycles after the iValid cycle that completes a window, provided the intervening iValid cycles are contiguous.
- Under stalls, each result appears 3 accepted pixels (or DRAIN cycles) after its completing pixel. oValid is never asserted on consecutive cycles more often than pixels are accepted.
- Throughput: 1 pixel/cycle sustained. No backpressure; oValid must be consumed when asserted.
- oBusy rises the cycle after iStart and falls the cycle after oDone.

## Configuration
- CNN_RELU_EN defined:
  - Negative shifted sums output 0.
  - Positive sums saturate to 2^DATA_WIDTH−1.
  - oResult is unsigned.
- CNN_RELU_EN undefined:
  - Shifted sums saturate to the signed range [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - oResult is two's complement.

## Test plan
All scenarios use defaults unless stated (IMAGE_WIDTH = IMAGE_HEIGHT = 16, DATA_WIDTH = 8, SHIFT = 0).
- Identity weights, pixel(r,c) = 16r+c, contiguous stream → 196 results. First result = 0x11 (pixel(1,1)), last = 0xEE (pixel(14,14)). oDone coincides with the last result; first oValid is 3 cycles after pixel(2,2).
- All weights = 1, constant pixel 10 → 196 results, each 90. With SHIFT = 2 → each 22.
- All weights = 1, constant pixel 255 (sum 2295) → each 255 with CNN_RELU_EN; each 127 (0x7F) without.
- w[4] = −1, others 0, constant pixel 5 → each 0 with CNN_RELU_EN; each 0xFB (−5) without.
- Ramp frame with random 1–3 cycle iValid gaps, plus iStart and iWeightWe pulsed mid-frame → results identical to the contiguous run. Extra iStart and weight writes have no effect.
- iRst asserted after 100 pixels, then a new iStart and a full identity frame → outputs 0 during reset, then exactly 196 correct results and one oDone.
